// File: rtl/mux_4_1_arb.sv
// Four-channel round-robin arbitrating multiplexer with a single registered
// output slot and valid/ready handshaking on both sides.
module mux_4_1_arb #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         i_valid,
    input  logic [4*WIDTH-1:0] i_data,
    output logic [3:0]         i_ready,
    output logic               y_valid,
    output logic [WIDTH-1:0]   y_data,
    output logic [1:0]         y_sel,
    input  logic               y_ready
);

    logic             y_valid_q, y_valid_d;
    logic [WIDTH-1:0] y_data_q,  y_data_d;
    logic [1:0]       y_sel_q,   y_sel_d;
    logic [1:0]       prio_ptr_q, prio_ptr_d;

    logic             load_en;
    logic             any_req;
    logic [3:0]       req_rot;
    logic [1:0]       grant_off;
    logic [1:0]       grant_idx;
    logic [3:0]       grant;
    logic [WIDTH-1:0] word [4];

    // req_rot[j] is the request of channel prio_ptr+j, so bit 0 has top priority.
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        localparam logic [1:0] OFF = 2'(gi);
        assign word[gi]    = i_data[gi*WIDTH +: WIDTH];
        assign req_rot[gi] = i_valid[prio_ptr_q + OFF];
        assign grant[gi]   = any_req && (grant_idx == OFF);
    end

    assign load_en = ~y_valid_q | y_ready;
    assign any_req = |i_valid;

    always_comb begin
        grant_off = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (req_rot[j]) begin
                grant_off = 2'(j);
            end
        end
        grant_idx = prio_ptr_q + grant_off;
    end

    // Held low during reset so no upstream word is dropped on the floor.
    assign i_ready = (rst_n && load_en) ? grant : 4'b0000;

    always_comb begin
        y_valid_d  = y_valid_q;
        y_data_d   = y_data_q;
        y_sel_d    = y_sel_q;
        prio_ptr_d = prio_ptr_q;
        if (load_en) begin
            if (any_req) begin
                y_valid_d  = 1'b1;
                y_data_d   = word[grant_idx];
                y_sel_d    = grant_idx;
                prio_ptr_d = grant_idx + 2'd1;
            end else begin
                y_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid_q  <= 1'b0;
            y_data_q   <= '0;
            y_sel_q    <= 2'd0;
            prio_ptr_q <= 2'd0;
        end else begin
            y_valid_q  <= y_valid_d;
            y_data_q   <= y_data_d;
            y_sel_q    <= y_sel_d;
            prio_ptr_q <= prio_ptr_d;
        end
    end

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_sel   = y_sel_q;

endmodule

// File: tb/tb_mux_4_1_arb.sv
// Bench for mux_4_1_arb: reference arbiter model plus a word scoreboard,
// driven by directed scenarios and a random back-to-back stream.
module tb_mux_4_1_arb;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [3:0]         i_valid = 4'b0;
    logic [4*WIDTH-1:0] i_data = '0;
    logic [3:0]         i_ready;
    logic               y_valid;
    logic [WIDTH-1:0]   y_data;
    logic [1:0]         y_sel;
    logic               y_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [1:0]       sel;
        logic [WIDTH-1:0] data;
    } word_t;

    word_t sb_q[$];

    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_data = '0;
    logic [1:0]       m_sel = 2'd0;
    logic [1:0]       m_ptr = 2'd0;

    mux_4_1_arb #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_ready (i_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_sel   (y_sel),
        .y_ready (y_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] exp_grant(input logic [1:0] ptr, input logic [3:0] v);
        logic [3:0] g;
        logic [1:0] idx;
        g = 4'b0;
        for (int j = 0; j < 4; j++) begin
            idx = ptr + 2'(j);
            if (v[idx] && g == 4'b0) g[idx] = 1'b1;
        end
        return g;
    endfunction

    task automatic set_word(input int k, input logic [WIDTH-1:0] d);
        i_data[k*WIDTH +: WIDTH] = d;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 2'd0;
        m_ptr   = 2'd0;
        sb_q.delete();
    endtask

    // One clock cycle: check i_ready, consume/compare via scoreboard, advance model.
    task automatic step();
        logic [3:0] g;
        logic [3:0] exp_rdy;
        word_t      w;
        #1;
        g = exp_grant(m_ptr, i_valid);
        exp_rdy = (!m_valid || y_ready) ? g : 4'b0;
        vectors++;
        if (i_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL i_ready: got %b expected %b", i_ready, exp_rdy);
        end
        if (y_valid === 1'b1 && y_ready) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_extra: got sel=%0d data=%h expected no word", y_sel, y_data);
            end else begin
                w = sb_q.pop_front();
                if (y_sel !== w.sel || y_data !== w.data) begin
                    miscompares++;
                    $display("FAIL sb_word: got sel=%0d data=%h expected sel=%0d data=%h",
                             y_sel, y_data, w.sel, w.data);
                end
            end
        end
        if (!m_valid || y_ready) begin
            if (g != 4'b0) begin
                for (int k = 0; k < 4; k++) begin
                    if (g[k]) begin
                        m_sel   = 2'(k);
                        m_data  = i_data[k*WIDTH +: WIDTH];
                        m_valid = 1'b1;
                        m_ptr   = 2'(k) + 2'd1;
                        w.sel   = m_sel;
                        w.data  = m_data;
                        sb_q.push_back(w);
                        $display("t=%0t xfer ch%0d data=%h", $time, k, m_data);
                    end
                end
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (y_valid !== m_valid || y_sel !== m_sel || y_data !== m_data) begin
            miscompares++;
            $display("FAIL out_regs: got v=%b sel=%0d data=%h expected v=%b sel=%0d data=%h",
                     y_valid, y_sel, y_data, m_valid, m_sel, m_data);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 4'b1111;
        y_ready = 1'b1;
        for (int k = 0; k < 4; k++) set_word(k, 8'h11 * k[7:0] + 8'h11);
        #2;
        vectors++;
        if (i_ready !== 4'b0 || y_valid !== 1'b0 || y_data !== '0 || y_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%b v=%b sel=%0d data=%h expected 0000/0/0/00",
                     i_ready, y_valid, y_sel, y_data);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (i_ready !== 4'b0 || y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got rdy=%b v=%b expected 0000/0", i_ready, y_valid);
        end
        #2;
        rst_n   = 1'b1;
        i_valid = 4'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_fairness();
        i_valid = 4'b1111;
        y_ready = 1'b1;
        for (int k = 0; k < 4; k++) set_word(k, 8'hA0 + k[7:0]);
        for (int n = 0; n < 5; n++) begin
            step();
            vectors++;
            if (y_sel !== 2'(n % 4) || y_data !== 8'hA0 + 8'(n % 4)) begin
                miscompares++;
                $display("FAIL fairness[%0d]: got sel=%0d data=%h expected sel=%0d data=%h",
                         n, y_sel, y_data, n % 4, 8'hA0 + 8'(n % 4));
            end
        end
    endtask

    task automatic test_backpressure();
        i_valid = 4'b0100;
        set_word(2, 8'h5C);
        y_ready = 1'b1;
        step();
        y_ready = 1'b0;
        set_word(2, 8'h5D);
        for (int n = 0; n < 3; n++) begin
            step();
            vectors++;
            if (y_valid !== 1'b1 || y_data !== 8'h5C || y_sel !== 2'd2 || i_ready !== 4'b0) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: got v=%b sel=%0d data=%h rdy=%b expected 1/2/5c/0000",
                         n, y_valid, y_sel, y_data, i_ready);
            end
        end
        y_ready = 1'b1;
        i_valid = 4'b0;
        step();
        vectors++;
        if (y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_consume: got v=%b expected 0", y_valid);
        end
    endtask

    task automatic test_single();
        i_valid = 4'b1000;
        y_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            set_word(3, 8'h30 + n[7:0]);
            #1;
            vectors++;
            if (i_ready !== 4'b1000) begin
                miscompares++;
                $display("FAIL single_rdy[%0d]: got %b expected 1000", n, i_ready);
            end
            step();
            vectors++;
            if (y_sel !== 2'd3 || y_data !== 8'h30 + n[7:0] || y_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL single_out[%0d]: got v=%b sel=%0d data=%h expected 1/3/%h",
                         n, y_valid, y_sel, y_data, 8'h30 + n[7:0]);
            end
        end
    endtask

    task automatic test_ptr_skip();
        i_valid = 4'b0001;
        set_word(0, 8'h40);
        step();
        i_valid = 4'b1001;
        set_word(3, 8'h43);
        set_word(0, 8'h44);
        step();
        vectors++;
        if (y_sel !== 2'd3 || y_data !== 8'h43) begin
            miscompares++;
            $display("FAIL skip_first: got sel=%0d data=%h expected 3/43", y_sel, y_data);
        end
        step();
        vectors++;
        if (y_sel !== 2'd0 || y_data !== 8'h44) begin
            miscompares++;
            $display("FAIL skip_wrap: got sel=%0d data=%h expected 0/44", y_sel, y_data);
        end
    endtask

    task automatic test_idle_drain();
        i_valid = 4'b0010;
        set_word(1, 8'h77);
        y_ready = 1'b1;
        step();
        i_valid = 4'b0;
        step();
        vectors++;
        if (y_valid !== 1'b0 || y_data !== 8'h77 || y_sel !== 2'd1) begin
            miscompares++;
            $display("FAIL idle_drain: got v=%b sel=%0d data=%h expected 0/1/77", y_valid, y_sel, y_data);
        end
        i_valid = 4'b1111;
        for (int k = 0; k < 4; k++) set_word(k, 8'hB0 + k[7:0]);
        step();
        vectors++;
        if (y_sel !== 2'd2 || y_data !== 8'hB2) begin
            miscompares++;
            $display("FAIL idle_ptr: got sel=%0d data=%h expected 2/b2", y_sel, y_data);
        end
    endtask

    task automatic test_reset_midstream();
        i_valid = 4'b0010;
        set_word(1, 8'h3C);
        y_ready = 1'b0;
        step();
        i_valid = 4'b1111;
        for (int k = 0; k < 4; k++) set_word(k, 8'hC0 + k[7:0]);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (y_valid !== 1'b0 || y_data !== '0 || y_sel !== 2'd0 || i_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b sel=%0d data=%h rdy=%b expected 0/0/00/0000",
                     y_valid, y_sel, y_data, i_ready);
        end
        model_reset();
        #2;
        rst_n   = 1'b1;
        y_ready = 1'b1;
        step();
        vectors++;
        if (y_sel !== 2'd0 || y_data !== 8'hC0) begin
            miscompares++;
            $display("FAIL post_reset_grant: got sel=%0d data=%h expected 0/c0", y_sel, y_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            i_valid = 4'($urandom_range(0, 15));
            y_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) set_word(k, 8'($urandom_range(0, 255)));
            step();
        end
        i_valid = 4'b0;
        y_ready = 1'b1;
        step();
        step();
        vectors++;
        if (sb_q.size() != 0 || y_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: got pending=%0d v=%b expected 0/0", sb_q.size(), y_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_single();
        test_ptr_skip();
        test_idle_drain();
        test_reset_midstream();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
